// File: rtl/fa_bist_pkg.sv
// Shared types and golden full-adder function for the adder BIST blocks.
package fa_bist_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned ERR_W   = 4;

  // Returns {carry, sum} for the vector idx = {A, B, Cin}.
  function automatic logic [1:0] fa_expected(input logic [IDX_W-1:0] idx);
    logic carry;
    carry = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
    return {carry, ^idx};
  endfunction

endpackage

// File: rtl/fa_golden_model.sv
// Combinational golden full adder indexed by the {A, B, Cin} vector number.
module fa_golden_model
  import fa_bist_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic             exp_sum,
  output logic             exp_carry
);

  always_comb begin
    {exp_carry, exp_sum} = fa_expected(idx);
  end

endmodule

// File: rtl/fa_bist_checker.sv
// Exhaustive stimulus generator and response checker for a 1-bit full adder.
module fa_bist_checker
  import fa_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned WAIT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_cin,
  input  logic             dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [IDX_W-1:0] first_fail_idx
);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [ERR_W-1:0]  err_nxt;
  logic              fail_valid_nxt;
  logic [IDX_W-1:0]  first_fail_nxt;
  logic              pass_nxt;
  logic              exp_sum, exp_carry;
  logic              mismatch;

  fa_golden_model u_golden (
    .idx       (idx),
    .exp_sum   (exp_sum),
    .exp_carry (exp_carry)
  );

  // Stimulus decoded straight from the registered vector index.
  assign dut_a   = idx[2];
  assign dut_b   = idx[1];
  assign dut_cin = idx[0];

  assign mismatch = (dut_sum != exp_sum) || (dut_carry != exp_carry);

  // Next-state and result update.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    wait_nxt       = wait_cnt;
    err_nxt        = err_count;
    fail_valid_nxt = fail_valid;
    first_fail_nxt = first_fail_idx;
    pass_nxt       = pass;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          idx_nxt        = '0;
          wait_nxt       = '0;
          err_nxt        = '0;
          fail_valid_nxt = 1'b0;
          first_fail_nxt = '0;
          pass_nxt       = 1'b0;
          state_nxt      = SETTLE;
        end
      end
      SETTLE: begin
        wait_nxt = wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_W'(SETTLE_CYCLES - 1)) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_nxt = err_count + ERR_W'(1);
          if (!fail_valid) begin
            fail_valid_nxt = 1'b1;
            first_fail_nxt = idx;
          end
        end
        if (idx == IDX_W'(NUM_VEC - 1)) begin
          pass_nxt  = (err_nxt == '0);
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          wait_nxt  = '0;
          state_nxt = SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and result registers; busy/done track the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      wait_cnt       <= '0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
      pass           <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      wait_cnt       <= wait_nxt;
      err_count      <= err_nxt;
      fail_valid     <= fail_valid_nxt;
      first_fail_idx <= first_fail_nxt;
      pass           <= pass_nxt;
      done           <= (state_nxt == DONE);
      busy           <= (state_nxt == SETTLE) || (state_nxt == CHECK);
    end
  end

endmodule

// File: tb/tb_fa_bist_checker.sv
// Self-checking bench for fa_bist_checker with a fault-injectable adder model.
module tb_fa_bist_checker;

  typedef struct {
    logic       pass;
    logic [3:0] err_count;
    logic       fail_valid;
    logic [2:0] first_fail_idx;
    int         latency;
  } result_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic       dut_a, dut_b, dut_cin, dut_sum, dut_carry;
  logic       busy, done, pass, fail_valid;
  logic [3:0] err_count;
  logic [2:0] first_fail_idx;
  logic       a1, b1, c1, sum1, carry1;
  logic       busy1, done1, pass1, fail_valid1;
  logic [3:0] err_count1;
  logic [2:0] first_fail_idx1;

  int fault;  // 0 good, 1 carry stuck-at-0, 2 sum inverted
  int n_checks = 0;
  int n_errors = 0;

  result_t    exp_q[$];
  logic [2:0] vec_q[$];

  always #5 clk = ~clk;

  // Adder under test, faults injected on the response.
  assign dut_sum   = (fault == 2) ? ~(dut_a ^ dut_b ^ dut_cin) : (dut_a ^ dut_b ^ dut_cin);
  assign dut_carry = (fault == 1) ? 1'b0 :
                     ((dut_a & dut_b) | (dut_a & dut_cin) | (dut_b & dut_cin));
  assign sum1      = a1 ^ b1 ^ c1;
  assign carry1    = (a1 & b1) | (a1 & c1) | (b1 & c1);

  fa_bist_checker u_dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
    .dut_sum(dut_sum), .dut_carry(dut_carry),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail_idx(first_fail_idx)
  );

  fa_bist_checker #(.SETTLE_CYCLES(1), .WAIT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_cin(c1),
    .dut_sum(sum1), .dut_carry(carry1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .fail_valid(fail_valid1), .first_fail_idx(first_fail_idx1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Independent model of the expected run outcome for a fault mode.
  function automatic result_t predict(input int f, input int settle);
    result_t r;
    logic a, b, c, gs, gc, ds, dc;
    r.err_count = 0; r.fail_valid = 0; r.first_fail_idx = 0;
    for (int i = 0; i < 8; i++) begin
      a = i[2]; b = i[1]; c = i[0];
      gs = a ^ b ^ c;
      gc = (a & b) | (a & c) | (b & c);
      ds = (f == 2) ? ~gs : gs;
      dc = (f == 1) ? 1'b0 : gc;
      if (ds != gs || dc != gc) begin
        if (!r.fail_valid) r.first_fail_idx = 3'(i);
        r.fail_valid = 1'b1;
        r.err_count++;
      end
    end
    r.pass    = (r.err_count == 0);
    r.latency = 8 * (settle + 1);
    return r;
  endfunction

  task automatic run_default(input int f, input bit mid_start);
    result_t e;
    int cyc;
    fault = f;
    exp_q.push_back(predict(f, 4));
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    check("clr_done", done, 0);
    check("clr_busy", busy, 1);
    check("clr_err", err_count, 0);
    check("clr_fv", fail_valid, 0);
    check("clr_pass", pass, 0);
    cyc = 0;
    while (!done && cyc < 200) begin
      start = mid_start && (cyc == 10 || cyc == 25);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check("latency", cyc, e.latency);
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("pass", pass, e.pass);
    check("err_count", err_count, e.err_count);
    check("fail_valid", fail_valid, e.fail_valid);
    if (e.fail_valid) check("first_fail_idx", first_fail_idx, e.first_fail_idx);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"},
          {busy, done, pass, err_count, fail_valid, first_fail_idx, dut_a, dut_b, dut_cin}, 0);
  endtask

  initial begin
    int cyc;
    logic [2:0] v;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; fault = 0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check_all_zero("post_reset");

    run_default(0, 1'b0);  // good adder
    run_default(1, 1'b0);  // carry stuck-at-0
    run_default(1, 1'b0);  // restart from DONE clears results
    run_default(2, 1'b0);  // sum inverted
    run_default(0, 1'b1);  // start pulses while busy are ignored

    // Reset mid-run at vector 4.
    fault = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while ({dut_a, dut_b, dut_cin} != 3'd4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_idx4", {dut_a, dut_b, dut_cin}, 3'd4);
    check("err_before_rst", err_count, 4);
    rst = 1'b1;
    #1 check_all_zero("mid_rst");
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    run_default(0, 1'b0);

    // Short settle window: every vector held two cycles.
    for (int i = 0; i < 8; i++) begin
      vec_q.push_back(3'(i));
      vec_q.push_back(3'(i));
    end
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    @(negedge clk) start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 100) begin
      if (vec_q.size() > 0) begin
        v = vec_q.pop_front();
        check("vec1", {a1, b1, c1}, v);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("latency1", cyc, 16);
    check("vec1_left", vec_q.size(), 0);
    check("pass1", pass1, 1);
    check("err1", err_count1, 0);
    check("fv1", fail_valid1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
